// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: pixel-side bundle between a video source and sprite_compositor.
// master drives layer flags/colours and frame timing; slave returns the composited pixel and collision status.
interface sprite_compositor_if #(
    parameter int N_LAYERS = 10,
    parameter int CNT_W    = 8
) ();
    logic                    video_on;
    logic                    frame_start;
    logic [N_LAYERS-1:0]     on_objs;
    logic [3*N_LAYERS-1:0]   rgb_objs;
    logic                    hit_clr;
    logic [2:0]              rgb;
    logic                    collision;
    logic [N_LAYERS-1:0]     collision_mask;
    logic [CNT_W-1:0]        hit_count;

    modport master (
        output video_on, frame_start, on_objs, rgb_objs, hit_clr,
        input  rgb, collision, collision_mask, hit_count
    );

    modport slave (
        input  video_on, frame_start, on_objs, rgb_objs, hit_clr,
        output rgb, collision, collision_mask, hit_count
    );
endinterface

// File: rtl/sprite_compositor.sv
// sprite_compositor: two-stage priority compositor (highest-index active layer wins) with per-frame player collision capture.
// Collision capture and hit counter are built only when SPRITE_COMPOSITOR_COLLISION_EN is defined.
module sprite_compositor #(
    parameter int                  N_LAYERS     = 10,
    parameter logic [N_LAYERS-1:0] COLLIDE_MASK = 10'b0111111000,
    parameter int                  CNT_W        = 8
) (
    input logic                clk,
    input logic                reset,
    sprite_compositor_if.slave bus
);
    logic [N_LAYERS-1:0]   on_q;
    logic [3*N_LAYERS-1:0] rgb_q;
    logic                  vid_q;
    logic                  fs_q;
    logic [2:0]            pix;
    logic [2:0]            rgb_r;
    logic                  coll;
    logic [N_LAYERS-1:0]   cmask;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_q  <= '0;
            rgb_q <= '0;
            vid_q <= 1'b0;
            fs_q  <= 1'b0;
            rgb_r <= 3'b000;
        end else begin
            on_q  <= bus.on_objs;
            rgb_q <= bus.rgb_objs;
            vid_q <= bus.video_on;
            fs_q  <= bus.frame_start;
            rgb_r <= pix;
        end
    end

    // Later (higher-index) layers overwrite earlier ones, so the top active layer wins.
    always_comb begin
        pix = 3'b000;
        for (int i = 0; i < N_LAYERS; i++)
            pix = on_q[i] ? rgb_q[3*i +: 3] : pix;
        pix = vid_q ? pix : 3'b000;
    end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    // The player layer can never collide with itself.
    localparam logic [N_LAYERS-1:0] HIT_MASK = {1'b0, COLLIDE_MASK[N_LAYERS-2:0]};
    logic [N_LAYERS-1:0] hit;
    logic [N_LAYERS-1:0] acc;

    assign hit = on_q & HIT_MASK & {N_LAYERS{on_q[N_LAYERS-1] & vid_q}};

    // The frame_start pixel opens the new frame, so its hits seed the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            coll  <= 1'b0;
            cmask <= '0;
            cnt   <= '0;
        end else begin
            acc <= fs_q ? hit : acc | hit;
            if (fs_q) begin
                cmask <= acc;
                coll  <= |acc;
            end
            cnt <= bus.hit_clr ? '0 : (fs_q && |acc && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
        end
    end
`else
    logic unused_ok;
    assign coll      = 1'b0;
    assign cmask     = '0;
    assign cnt       = '0;
    assign unused_ok = ^{bus.hit_clr, fs_q, COLLIDE_MASK};
`endif

    assign bus.rgb            = rgb_r;
    assign bus.collision      = coll;
    assign bus.collision_mask = cmask;
    assign bus.hit_count      = cnt;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized checks of sprite_compositor against a frame-level reference model.
// The collision expectations follow SPRITE_COMPOSITOR_COLLISION_EN exactly as the design build does.
module tb_sprite_compositor;
    localparam int N  = 10;
    localparam int CW = 2;
    localparam logic [N-1:0] CM = 10'b0111111000;
    localparam logic [CW-1:0] MAXC = {CW{1'b1}};
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int errs = 0;
    int checks = 0;

    sprite_compositor_if #(.N_LAYERS(N), .CNT_W(CW)) bus ();

    sprite_compositor #(.N_LAYERS(N), .COLLIDE_MASK(CM), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pixel seen at the previous edge, open-frame overlap set, published results.
    logic          p_vid, p_fs;
    logic [N-1:0]  p_on;
    logic [3*N-1:0] p_rgb;
    logic [N-1:0]  m_acc;
    logic [2:0]    e_rgb;
    logic          e_coll;
    logic [N-1:0]  e_mask;
    logic [CW-1:0] e_cnt;

    task automatic model_clear();
        p_vid = 0; p_fs = 0; p_on = '0; p_rgb = '0;
        m_acc = '0; e_rgb = '0; e_coll = 0; e_mask = '0; e_cnt = '0;
    endtask

    task automatic step(input logic v, input logic f, input logic [N-1:0] o, input logic [3*N-1:0] c, input logic h);
        logic [N-1:0] hv;
        logic found;
        bus.video_on = v; bus.frame_start = f; bus.on_objs = o; bus.rgb_objs = c; bus.hit_clr = h;
        @(posedge clk);
        e_rgb = 3'b000;
        found = 0;
        if (p_vid)
            for (int i = N - 1; i >= 0; i--)
                if (!found && p_on[i]) begin
                    e_rgb = p_rgb[3*i +: 3];
                    found = 1;
                end
        hv = '0;
        if (p_vid && p_on[N-1])
            for (int i = 0; i < N - 1; i++) hv[i] = p_on[i] & CM[i];
        if (EN) begin
            if (p_fs) begin
                e_mask = m_acc;
                e_coll = (m_acc != 0);
                if (e_coll && e_cnt != MAXC) e_cnt = e_cnt + 1'b1;
                m_acc = hv;
            end else m_acc = m_acc | hv;
            if (h) e_cnt = '0;
        end
        p_vid = v; p_fs = f; p_on = o; p_rgb = c;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        bus.video_on = 0; bus.frame_start = 0; bus.on_objs = '0; bus.rgb_objs = '0; bus.hit_clr = 0;
        reset = 1;
        model_clear();
        #2;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 10'b1111111111, 30'h3FFFFFFF, 0);
        step(1, 0, 10'b1000001000, 30'h3FFFFFFF, 0);
        bus.video_on = 0; bus.frame_start = 0; bus.on_objs = '0;
        reset = 1;
        #1;
        checks++; if (bus.rgb !== 3'b000) begin errs++; $display("FAIL reset_rgb got=%b want=000", bus.rgb); end
        checks++; if (bus.collision !== 1'b0) begin errs++; $display("FAIL reset_coll got=%b want=0", bus.collision); end
        checks++; if (bus.collision_mask !== '0) begin errs++; $display("FAIL reset_mask got=%b want=0", bus.collision_mask); end
        checks++; if (bus.hit_count !== '0) begin errs++; $display("FAIL reset_cnt got=%0d want=0", bus.hit_count); end
        do_reset();
    endtask

    task automatic test_priority();
        do_reset();
        step(1, 0, 10'b0000000101, 30'h181, 0);
        checks++; if (bus.rgb !== 3'b000) begin errs++; $display("FAIL prio_early got=%b want=000", bus.rgb); end
        step(1, 0, '0, '0, 0);
        checks++; if (bus.rgb !== 3'b110) begin errs++; $display("FAIL prio_rgb got=%b want=110", bus.rgb); end
        step(1, 0, '0, '0, 0);
        checks++; if (bus.rgb !== 3'b000) begin errs++; $display("FAIL prio_after got=%b want=000", bus.rgb); end
    endtask

    task automatic test_blanking();
        do_reset();
        step(0, 0, 10'b1111111111, 30'h2AAAAAAA, 0);
        step(1, 0, 10'b0000000000, 30'h3FFFFFFF, 0);
        checks++; if (bus.rgb !== 3'b000) begin errs++; $display("FAIL blank_video got=%b want=000", bus.rgb); end
        step(1, 0, '0, '0, 0);
        checks++; if (bus.rgb !== 3'b000) begin errs++; $display("FAIL blank_noobj got=%b want=000", bus.rgb); end
    endtask

    task automatic test_collision();
        do_reset();
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        step(1, 0, 10'b1000100000, 30'h3FFFFFFF, 0);
        idle(3);
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision !== EN) begin errs++; $display("FAIL coll_set got=%b want=%b", bus.collision, EN); end
        checks++; if (bus.collision_mask !== (EN ? 10'b0000100000 : 10'b0)) begin errs++; $display("FAIL coll_mask got=%b", bus.collision_mask); end
        checks++; if (bus.hit_count !== (EN ? 2'd1 : 2'd0)) begin errs++; $display("FAIL coll_cnt got=%0d", bus.hit_count); end
        idle(4);
        checks++; if (bus.collision !== EN) begin errs++; $display("FAIL coll_hold got=%b want=%b", bus.collision, EN); end
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision !== 1'b0) begin errs++; $display("FAIL coll_clear got=%b want=0", bus.collision); end
        checks++; if (bus.hit_count !== (EN ? 2'd1 : 2'd0)) begin errs++; $display("FAIL coll_cnt_keep got=%0d", bus.hit_count); end
    endtask

    task automatic test_boundary();
        do_reset();
        step(1, 1, '0, '0, 0);
        idle(2);
        step(1, 1, 10'b1000010000, 30'h3FFFFFFF, 0);
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision_mask !== 10'b0) begin errs++; $display("FAIL bnd_now got=%b want=0", bus.collision_mask); end
        step(1, 0, 10'b1000000001, 30'h3FFFFFFF, 0);
        idle(2);
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision_mask !== (EN ? 10'b0000010000 : 10'b0)) begin errs++; $display("FAIL bnd_next got=%b", bus.collision_mask); end
        step(1, 0, 10'b1000000111, 30'h3FFFFFFF, 0);
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision !== 1'b0) begin errs++; $display("FAIL bnd_low got=%b want=0", bus.collision); end
        checks++; if (bus.hit_count !== (EN ? 2'd1 : 2'd0)) begin errs++; $display("FAIL bnd_cnt got=%0d", bus.hit_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 1, '0, '0, 0);
        step(1, 0, 10'b1000001000, 30'h3FFFFFFF, 0);
        step(1, 1, 10'b1010000000, 30'h3FFFFFFF, 0);
        step(1, 1, '0, '0, 0);
        checks++; if (bus.collision_mask !== (EN ? 10'b0000001000 : 10'b0)) begin errs++; $display("FAIL b2b_first got=%b", bus.collision_mask); end
        step(1, 1, '0, '0, 0);
        checks++; if (bus.collision_mask !== (EN ? 10'b0010000000 : 10'b0)) begin errs++; $display("FAIL b2b_second got=%b", bus.collision_mask); end
        checks++; if (bus.hit_count !== (EN ? 2'd2 : 2'd0)) begin errs++; $display("FAIL b2b_cnt got=%0d", bus.hit_count); end
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision_mask !== 10'b0) begin errs++; $display("FAIL b2b_third got=%b want=0", bus.collision_mask); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 10'b1001000000, 30'h3FFFFFFF, 0);
            step(1, 1, '0, '0, 0);
            step(1, 0, '0, '0, 0);
        end
        checks++; if (bus.hit_count !== (EN ? 2'd3 : 2'd0)) begin errs++; $display("FAIL sat_cnt got=%0d", bus.hit_count); end
        step(1, 0, 10'b1001000000, 30'h3FFFFFFF, 0);
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 1);
        checks++; if (bus.hit_count !== 2'd0) begin errs++; $display("FAIL clr_cnt got=%0d want=0", bus.hit_count); end
        checks++; if (bus.collision !== EN) begin errs++; $display("FAIL clr_coll got=%b want=%b", bus.collision, EN); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        step(1, 1, '0, '0, 0);
        step(1, 0, 10'b1000100000, 30'h3FFFFFFF, 0);
        step(1, 0, '0, '0, 0);
        do_reset();
        step(1, 1, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        checks++; if (bus.collision !== 1'b0) begin errs++; $display("FAIL rstmid_coll got=%b want=0", bus.collision); end
        checks++; if (bus.collision_mask !== 10'b0) begin errs++; $display("FAIL rstmid_mask got=%b want=0", bus.collision_mask); end
        checks++; if (bus.hit_count !== 2'd0) begin errs++; $display("FAIL rstmid_cnt got=%0d want=0", bus.hit_count); end
    endtask

    task automatic test_random();
        logic [N-1:0] o;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            o = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 2) == 0) o[N-1] = 1'b1;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, o, 30'($urandom), $urandom_range(0, 40) == 0);
            checks++; if (bus.rgb !== e_rgb) begin errs++; $display("FAIL rnd_rgb k=%0d got=%b want=%b", k, bus.rgb, e_rgb); end
            checks++; if (bus.collision !== e_coll) begin errs++; $display("FAIL rnd_coll k=%0d got=%b want=%b", k, bus.collision, e_coll); end
            checks++; if (bus.collision_mask !== e_mask) begin errs++; $display("FAIL rnd_mask k=%0d got=%b want=%b", k, bus.collision_mask, e_mask); end
            checks++; if (bus.hit_count !== e_cnt) begin errs++; $display("FAIL rnd_cnt k=%0d got=%0d want=%0d", k, bus.hit_count, e_cnt); end
        end
    endtask

    initial begin
        bus.video_on = 0; bus.frame_start = 0; bus.on_objs = '0; bus.rgb_objs = '0; bus.hit_clr = 0;
        model_clear();
        do_reset();
        test_reset();
        test_priority();
        test_blanking();
        test_collision();
        test_boundary();
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 The block SHALL have parameter N_LAYERS, default 10, giving the number of layers (minimum 2).
REQ-002 The block SHALL have parameter COLLIDE_MASK, N_LAYERS bits, default 10'b0111111000, marking the layers that can collide with the player layer.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the hit counter.
REQ-004 clk  input  1  pixel clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 video_on  input  1  current pixel is in the visible area.
REQ-007 frame_start  input  1  single-cycle pulse coincident with the first pixel of a frame.
REQ-008 on_objs  input  N_LAYERS  layer-active flags; bit N_LAYERS-1 is the player and has highest priority; bit 0 has lowest priority.
REQ-009 rgb_objs  input  3*N_LAYERS  per-layer colour; bits [3i+2:3i] belong to layer i.
REQ-010 hit_clr  input  1  synchronous clear of hit_count.
REQ-011 rgb  output  3  composited colour.
REQ-012 collision  output  1  previous frame contained at least one player overlap.
REQ-013 collision_mask  output  N_LAYERS  layers that overlapped the player during the previous frame.
REQ-014 hit_count  output  CNT_W  saturating count of frames that contained a collision.

Function
REQ-015 Stage 1 SHALL register on_objs, rgb_objs, video_on and frame_start on every clk edge.
REQ-016 Stage 2 SHALL register rgb as the colour of the highest-index active layer from the stage-1 values, giving a fixed latency of 2 cycles.
REQ-017 rgb SHALL be 3'b000 when the stage-1 video_on is 0 or when no layer is active.
REQ-018 The per-pixel hit vector SHALL be on_objs[i] & COLLIDE_MASK[i] & on_objs[N_LAYERS-1] & video_on, computed from stage-1 values, for each i < N_LAYERS-1; bit N_LAYERS-1 of the hit vector SHALL be 0.
REQ-019 An internal accumulator SHALL OR the hit vector into itself every cycle.
REQ-020 On a cycle where the stage-1 frame_start is 1, the block SHALL perform all of the following in that same cycle:
- collision_mask <= accumulator;
- collision <= |accumulator;
- if |accumulator is 1, hit_count increments by 1;
- the accumulator is loaded with that cycle's hit vector, because the frame_start pixel belongs to the new frame.
REQ-021 hit_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 When hit_clr is 1, hit_count SHALL become 0 on the next edge; hit_clr SHALL win over a simultaneous increment.
REQ-023 collision and collision_mask SHALL hold their values for a whole frame and change only on frame_start.
REQ-024 Back-to-back frame_start pulses SHALL each publish the accumulator independently, with no loss and no merge.
REQ-025 Bits of on_objs outside COLLIDE_MASK, including bit 0, SHALL never set any collision output.

Reset
REQ-026 Reset SHALL clear the following to 0 immediately and asynchronously: all pipeline registers, the accumulator, rgb, collision, collision_mask and hit_count.
REQ-027 Reset asserted mid-frame SHALL discard the partial accumulation.
REQ-028 After reset, the first frame_start SHALL publish only the hits seen since reset was released.

Configuration
REQ-029 With macro SPRITE_COMPOSITOR_COLLISION_EN defined, REQ-018 to REQ-025 SHALL be implemented.
REQ-030 With SPRITE_COMPOSITOR_COLLISION_EN undefined, the following SHALL be tied to 0 and no accumulator or counter logic SHALL be built: collision, collision_mask and hit_count.
REQ-031 rgb behaviour and latency SHALL be identical whether or not SPRITE_COMPOSITOR_COLLISION_EN is defined.

Verification
REQ-032 Priority: on_objs=10'b0000000101, layer 2 colour 3'b110, layer 0 colour 3'b001, video_on=1 -> rgb=3'b110 exactly 2 cycles later.
REQ-033 Blanking: video_on=0 with on_objs all set -> rgb=3'b000 after 2 cycles; on_objs=0 with video_on=1 -> rgb=3'b000.
REQ-034 Collision: drive bits 9 and 5 high for one visible pixel mid-frame, then pulse frame_start -> two cycles after the pulse, collision=1, collision_mask=10'b0000100000 and hit_count=1; after the next frame_start with no overlap, collision=0 and hit_count stays 1.
REQ-035 Boundary:
- an overlap on bits 9 and 4 presented in the frame_start cycle itself is reported one frame later, not in the current publication;
- an overlap on bits 9 and 0 is never reported.
REQ-036 Saturation and clear, with CNT_W=2:
- five colliding frames -> hit_count=3;
- hit_clr asserted together with a frame_start that carries a collision -> hit_count=0.
REQ-037 Reset: assert reset mid-frame after an overlap, release it, then pulse frame_start -> collision=0, collision_mask=0, hit_count=0.
